// File: rtl/conv1d_par_layer.sv
// 1-D valid-mode convolution with P parallel MAC lanes, runtime-loaded filter,
// per-output saturation to WIDTH bits and optional ReLU.
module conv1d_par_layer #(
  parameter int WIDTH = 16,
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int P     = 8,
  parameter int RELU  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_f,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  input  logic [WIDTH-1:0] s_data_in_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic [WIDTH-1:0] m_data_out_y,
  output logic             m_valid_y,
  input  logic             m_ready_y
);
  localparam int SIZE = LENX - LENF + 1;
  localparam int AW   = (LENX > 1) ? $clog2(LENX) : 1;
  localparam int FAW  = (LENF > 1) ? $clog2(LENF) : 1;
  localparam int ACCW = 2*WIDTH + $clog2(LENF);
  localparam int CW   = $clog2(LENF + 2);
  localparam int PW   = (P > 1) ? $clog2(P) : 1;

  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {LOAD_F, LOAD_X, COMPUTE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]           c_q, c_d;
  logic [AW-1:0]           b_q, b_d;
  logic [PW-1:0]           d_q, d_d;
  logic                    m_valid_q, m_valid_d;
  logic [WIDTH-1:0]        m_data_q, m_data_d;
  logic signed [ACCW-1:0]  acc_q [P];
  logic signed [ACCW-1:0]  acc_d [P];
  logic [WIDTH-1:0]        ybuf_q [P];
  logic [WIDTH-1:0]        ybuf_d [P];

  logic signed [WIDTH-1:0] f_mem [LENF];
  logic signed [WIDTH-1:0] x_mem [LENX];
  logic signed [WIDTH-1:0] f_rd_q;
  logic signed [WIDTH-1:0] x_rd_q [P];
  logic [FAW-1:0]          f_raddr;
  logic [AW-1:0]           x_raddr [P];
  logic                    f_we, x_we;
  int                      drain_rem, drain_last;

  function automatic logic [WIDTH-1:0] sat(input logic signed [ACCW-1:0] a);
    logic [WIDTH-1:0] r;
    if (a > MAXV)      r = {1'b0, {(WIDTH-1){1'b1}}};
    else if (a < MINV) r = {1'b1, {(WIDTH-1){1'b0}}};
    else               r = a[WIDTH-1:0];
    if (RELU != 0 && r[WIDTH-1]) r = '0;
    return r;
  endfunction

  // Lane j reads x[b+j+c]; out-of-range addresses only feed inactive lanes.
  always_comb begin
    for (int j = 0; j < P; j++) begin
      x_raddr[j] = '0;
      if (int'(b_q) + j + int'(c_q) < LENX) x_raddr[j] = AW'(int'(b_q) + j + int'(c_q));
    end
    f_raddr = '0;
    if (int'(c_q) < LENF) f_raddr = FAW'(c_q);
  end

  always_ff @(posedge clk) begin
    if (reset && f_we) f_mem[ld_cnt_q[FAW-1:0]] <= s_data_in_f;
    if (reset && x_we) x_mem[ld_cnt_q] <= s_data_in_x;
    f_rd_q <= f_mem[f_raddr];
    for (int j = 0; j < P; j++) x_rd_q[j] <= x_mem[x_raddr[j]];
  end

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    c_d       = c_q;
    b_d       = b_q;
    d_d       = d_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    acc_d     = acc_q;
    ybuf_d    = ybuf_q;
    f_we      = 1'b0;
    x_we      = 1'b0;
    drain_rem  = SIZE - int'(b_q);
    drain_last = ((drain_rem < P) ? drain_rem : P) - 1;
    case (state_q)
      LOAD_F: if (s_valid_f) begin
        f_we = 1'b1;
        if (ld_cnt_q == AW'(LENF - 1)) begin
          ld_cnt_d = '0;
          state_d  = LOAD_X;
        end else begin
          ld_cnt_d = ld_cnt_q + AW'(1);
        end
      end
      LOAD_X: if (s_valid_x) begin
        x_we = 1'b1;
        if (ld_cnt_q == AW'(LENX - 1)) begin
          ld_cnt_d = '0;
          b_d      = '0;
          c_d      = '0;
          state_d  = COMPUTE;
        end else begin
          ld_cnt_d = ld_cnt_q + AW'(1);
        end
      end
      COMPUTE: begin
        c_d = c_q + CW'(1);
        // c=0 is the read-latency cycle, c=1..LENF accumulate, c=LENF+1 saturates
        if (c_q == '0) begin
          for (int j = 0; j < P; j++) acc_d[j] = '0;
        end else if (int'(c_q) <= LENF) begin
          for (int j = 0; j < P; j++)
            acc_d[j] = acc_q[j] + ACCW'(x_rd_q[j]) * ACCW'(f_rd_q);
        end else begin
          for (int j = 0; j < P; j++) ybuf_d[j] = sat(acc_q[j]);
          m_data_d  = sat(acc_q[0]);
          m_valid_d = 1'b1;
          d_d       = '0;
          c_d       = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: if (m_ready_y) begin
        if (int'(d_q) == drain_last) begin
          m_valid_d = 1'b0;
          if (int'(b_q) + P < SIZE) begin
            b_d     = b_q + AW'(P);
            state_d = COMPUTE;
          end else begin
            state_d = LOAD_X;
          end
        end else begin
          d_d      = d_q + PW'(1);
          m_data_d = ybuf_q[d_q + PW'(1)];
        end
      end
      default: state_d = LOAD_F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= LOAD_F;
      ld_cnt_q  <= '0;
      c_q       <= '0;
      b_q       <= '0;
      d_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      for (int j = 0; j < P; j++) begin
        acc_q[j]  <= '0;
        ybuf_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      c_q       <= c_d;
      b_q       <= b_d;
      d_q       <= d_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      for (int j = 0; j < P; j++) begin
        acc_q[j]  <= acc_d[j];
        ybuf_q[j] <= ybuf_d[j];
      end
    end
  end

  assign s_ready_f    = (state_q == LOAD_F);
  assign s_ready_x    = (state_q == LOAD_X);
  assign m_valid_y    = m_valid_q;
  assign m_data_out_y = m_data_q;

endmodule

// File: tb/tb_conv1d_par_layer.sv
// Directed bench for conv1d_par_layer: default, saturation, ReLU, partial last
// pass, backpressure and mid-frame reset, against hand-computed outputs.
`timescale 1ns/1ps
module tb_conv1d_par_layer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] f_data, x_data, sf_data, sx_data;
  logic        f_valid, x_valid, sf_valid, sx_valid, m_ready;
  logic        d_rf, d_rx, d_v, l_rf, l_rx, l_v, s_rf, s_rx, s_v;
  logic [15:0] d_y, l_y, s_y;

  int checks = 0;
  int failures = 0;
  int exp_a [32];
  int exp_b [32];
  int lat, quiet;

  conv1d_par_layer #(.WIDTH(16), .LENX(64), .LENF(33), .P(8), .RELU(1)) u_def (
    .clk(clk), .reset(rst_n),
    .s_data_in_f(f_data), .s_valid_f(f_valid), .s_ready_f(d_rf),
    .s_data_in_x(x_data), .s_valid_x(x_valid), .s_ready_x(d_rx),
    .m_data_out_y(d_y), .m_valid_y(d_v), .m_ready_y(m_ready));

  conv1d_par_layer #(.WIDTH(16), .LENX(64), .LENF(33), .P(8), .RELU(0)) u_lin (
    .clk(clk), .reset(rst_n),
    .s_data_in_f(f_data), .s_valid_f(f_valid), .s_ready_f(l_rf),
    .s_data_in_x(x_data), .s_valid_x(x_valid), .s_ready_x(l_rx),
    .m_data_out_y(l_y), .m_valid_y(l_v), .m_ready_y(m_ready));

  conv1d_par_layer #(.WIDTH(16), .LENX(9), .LENF(3), .P(4), .RELU(1)) u_small (
    .clk(clk), .reset(rst_n),
    .s_data_in_f(sf_data), .s_valid_f(sf_valid), .s_ready_f(s_rf),
    .s_data_in_x(sx_data), .s_valid_x(sx_valid), .s_ready_x(s_rx),
    .m_data_out_y(s_y), .m_valid_y(s_v), .m_ready_y(m_ready));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_f(input bit sm, input logic [15:0] v);
    int t;
    t = 0;
    if (sm) begin sf_data = v; sf_valid = 1'b1; end
    else begin f_data = v; f_valid = 1'b1; end
    while (!(sm ? s_rf : d_rf) && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("f_ready_timeout", sm ? s_rf : d_rf, 1);
    @(posedge clk); #1;
    sf_valid = 1'b0;
    f_valid  = 1'b0;
  endtask

  task automatic push_x(input bit sm, input logic [15:0] v);
    int t;
    t = 0;
    if (sm) begin sx_data = v; sx_valid = 1'b1; end
    else begin x_data = v; x_valid = 1'b1; end
    while (!(sm ? s_rx : d_rx) && t < 2000) begin @(posedge clk); #1; t++; end
    if (t >= 2000) chk("x_ready_timeout", sm ? s_rx : d_rx, 1);
    @(posedge clk); #1;
    sx_valid = 1'b0;
    x_valid  = 1'b0;
  endtask

  // Accepts n outputs starting at exp index base; checks hold-stability on stalls.
  task automatic collect(input bit sm, input int n, input int base, input int duty, input string tag);
    int got, t;
    bit pend;
    logic [15:0] pd;
    got = 0; t = 0; pend = 1'b0; pd = '0;
    while (got < n && t < 20000) begin
      m_ready = ($urandom_range(99) < duty);
      if (sm ? s_v : d_v) begin
        if (m_ready) begin
          if (sm) chk(tag, $signed(s_y), exp_a[base+got]);
          else begin
            chk(tag, $signed(d_y), exp_a[base+got]);
            chk({tag, "_lin"}, $signed(l_y), exp_b[base+got]);
          end
          got++;
        end else begin
          pend = 1'b1;
          pd   = sm ? s_y : d_y;
        end
      end
      @(posedge clk); #1; t++;
      if (pend) begin
        chk({tag, "_stall_valid"}, sm ? s_v : d_v, 1);
        chk({tag, "_stall_data"}, sm ? s_y : d_y, pd);
        pend = 1'b0;
      end
    end
    m_ready = 1'b0;
    if (got < n) chk({tag, "_timeout"}, got, n);
    $display("collect %s: %0d outputs", tag, got);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; m_ready = 1'b0;
    f_data = '0; x_data = '0; f_valid = 1'b0; x_valid = 1'b0;
    sf_data = '0; sx_data = '0; sf_valid = 1'b0; sx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_f", d_rf, 1);
    chk("rst_ready_x", d_rx, 0);
    chk("rst_valid", d_v, 0);
    chk("rst_data", d_y, 0);
    chk("rst_small_ready_f", s_rf, 1);
    rst_n = 1'b1;

    // Partial last pass: LENX=9, LENF=3, P=4, f={1,2,3}, x=n -> 6k+8
    for (int i = 0; i < 3; i++) push_f(1'b1, 16'(i + 1));
    chk("sm_ready_x", s_rx, 1);
    for (int i = 0; i < 9; i++) push_x(1'b1, 16'(i));
    for (int k = 0; k < 7; k++) exp_a[k] = 6*k + 8;
    collect(1'b1, 4, 0, 100, "sm_pass0");
    chk("sm_pass0_valid_fall", s_v, 0);
    collect(1'b1, 3, 4, 100, "sm_pass1");
    chk("sm_end_valid", s_v, 0);
    chk("sm_end_ready_x", s_rx, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("sm_no_extra", s_v, 0);

    // Default frame f=1, x=n; filter-stream noise during x load must be ignored
    for (int i = 0; i < 33; i++) push_f(1'b0, 16'd1);
    f_valid = 1'b1; f_data = 16'h7fff;
    for (int i = 0; i < 64; i++) push_x(1'b0, 16'(i));
    f_valid = 1'b0;
    lat = 0;
    while (!d_v && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, 35);
    for (int k = 0; k < 32; k++) begin exp_a[k] = 33*k + 528; exp_b[k] = 33*k + 528; end
    collect(1'b0, 32, 0, 100, "dflt");
    chk("dflt_end_valid", d_v, 0);
    chk("dflt_end_ready_x", d_rx, 1);

    // Positive saturation, then negative saturation with the retained filter
    do_reset();
    for (int i = 0; i < 33; i++) push_f(1'b0, 16'h7fff);
    for (int i = 0; i < 64; i++) push_x(1'b0, 16'h7fff);
    for (int k = 0; k < 32; k++) begin exp_a[k] = 32767; exp_b[k] = 32767; end
    collect(1'b0, 32, 0, 100, "sat_pos");
    for (int i = 0; i < 64; i++) push_x(1'b0, 16'h8000);
    for (int k = 0; k < 32; k++) begin exp_a[k] = 0; exp_b[k] = -32768; end
    collect(1'b0, 32, 0, 100, "sat_neg");

    // ReLU: f=-1, x=1 -> -33 before clamping
    do_reset();
    for (int i = 0; i < 33; i++) push_f(1'b0, 16'hffff);
    for (int i = 0; i < 64; i++) push_x(1'b0, 16'd1);
    for (int k = 0; k < 32; k++) begin exp_a[k] = 0; exp_b[k] = -33; end
    collect(1'b0, 32, 0, 100, "relu");

    // Backpressure at 30% ready duty
    do_reset();
    for (int i = 0; i < 33; i++) push_f(1'b0, 16'd1);
    for (int i = 0; i < 64; i++) push_x(1'b0, 16'(i));
    for (int k = 0; k < 32; k++) begin exp_a[k] = 33*k + 528; exp_b[k] = 33*k + 528; end
    collect(1'b0, 32, 0, 30, "bp");
    chk("bp_end_valid", d_v, 0);

    // Reset during the second pass's COMPUTE, then a fresh frame x=2n
    do_reset();
    for (int i = 0; i < 33; i++) push_f(1'b0, 16'd1);
    for (int i = 0; i < 64; i++) push_x(1'b0, 16'(i));
    collect(1'b0, 8, 0, 100, "mid_p0");
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", d_v, 0);
    chk("midrst_ready_f", d_rf, 1);
    chk("midrst_ready_x", d_rx, 0);
    chk("midrst_data", d_y, 0);
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 50; i++) begin @(posedge clk); #1; if (d_v) quiet++; end
    chk("midrst_no_output", quiet, 0);
    for (int i = 0; i < 33; i++) push_f(1'b0, 16'd1);
    for (int i = 0; i < 64; i++) push_x(1'b0, 16'(2*i));
    for (int k = 0; k < 32; k++) begin exp_a[k] = 66*k + 1056; exp_b[k] = 66*k + 1056; end
    collect(1'b0, 32, 0, 100, "after_rst");
    chk("after_rst_end_valid", d_v, 0);
    chk("after_rst_ready_x", d_rx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
